syn_down_counter: RTL and testbench
===================================

# syn_down_counter

Synchronous, loadable down counter with an integrated clock-enable prescaler, terminal-count pulse and wrap/one-shot modes. It complements the lab's synchronous up counter: the same flip-flop counting discipline, but counting toward zero from a loaded value. It drives board LEDs/HEX and timeout logic. All state advances on `clk`; the prescaler produces a one-cycle enable tick and never a derived clock.

## Interface
- `WIDTH`, default 4: counter width in bits; maximum value is 2^WIDTH-1.
- `DIV_BITS`, default 5: prescaler width; one count tick every 2^DIV_BITS enabled `clk` cycles. A value of 0 gives a tick every enabled cycle.

- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: reset; one clock, synchronous, active-high.
- `en`  in  1: count enable; when low, the prescaler and counter hold.
- `load`  in  1: load strobe.
- `load_val`  in  WIDTH: value captured on `load`.
- `mode`  in  1: captured on `load`. 0 selects wrap; 1 selects one-shot.
- `out`  out  WIDTH: current count (registered).
- `tc`  out  1: terminal-count pulse (registered).
- `busy`  out  1: high while in state RUN (registered).

## Operation
- Priority, evaluated each rising edge: `rst` > `load` > tick.
- Reset values:
  - `out`=0, `tc`=0, `busy`=0.
  - Prescaler=0, latched mode=0, state=IDLE.
- States are IDLE, RUN and HALT.
  - **IDLE**: entered only from reset. `out` holds. Leaves only on `load`.
  - **RUN**: decrements `out` by 1 on each tick.
  - **HALT**: one-shot finished. `out` holds at 0. Leaves only on `load` or `rst`.
- Load is accepted in any state.
  - `out`←`load_val`, mode latch←`mode`, prescaler←0.
  - Next state is RUN, except a one-shot load of 0, which goes directly to HALT with no `tc`.
- Tick condition: state is RUN, `en`=1, and the prescaler equals all-ones (or `DIV_BITS`=0). The prescaler increments modulo 2^DIV_BITS on every RUN cycle with `en`=1 and holds otherwise.
- Tick with `out`=1:
  - `out`←0 and `tc`=1 for that cycle.
  - In one-shot mode, state→HALT.
- Tick with `out`=0 (wrap mode only): `out`←2^WIDTH-1, with no `tc`.
- Tick with `out`>1: `out`←`out`-1.
- Arithmetic is unsigned and modulo 2^WIDTH; no borrow output.
- `en` low: `out`, prescaler and state are frozen. `tc` is 0.
- `load` on the same edge as a tick: the load wins, the tick is discarded and no `tc` is issued.

## Timing
- Load asserted for edge k: `out`=`load_val` and `busy`=1 after edge k (one-cycle latency).
- First decrement occurs at the 2^DIV_BITS-th enabled RUN cycle after the load edge. Subsequent decrements follow every 2^DIV_BITS enabled cycles.
- `tc` is high for exactly one `clk` cycle, coincident with the first cycle `out` reads 0.
- In one-shot mode, `busy` falls on that same edge.
- `rst` mid-run: outputs reach their reset values after the next edge, regardless of `load`/`en`.

## Configuration
- `SYN_DOWN_COUNTER_PRESCALE_EN`
  - **Defined**: prescaler is present as described above.
  - **Undefined**: no prescaler registers are built and `DIV_BITS` is ignored. A tick occurs on every RUN cycle with `en`=1. All other behaviour is unchanged.

## Test plan
Settings: WIDTH=4, DIV_BITS=2, macro defined unless noted.
- **Reset and idle**: hold `rst`=1 for 2 cycles, then `en`=1 with no load for 20 cycles → `out`=0, `tc`=0 and `busy`=0 throughout.
- **One-shot countdown**: `load_val`=5, `mode`=1, `en`=1.
  - `out` steps 5,4,3,2,1,0, one step per 4 cycles.
  - `tc`=1 for one cycle as `out`=0, and `busy` falls on that edge.
  - `out` then stays 0 for 20 more cycles.
- **Wrap mode**: `load_val`=2, `mode`=0 → `out` steps 2,1,0,15,14,13. `tc` pulses only at 1→0, exactly once.
- **Enable gap**: `load_val`=9, `mode`=1; drop `en` for 10 cycles two cycles after a decrement → `out` is frozen. After `en` returns, the next decrement comes 2 enabled cycles later.
- **Collisions**:
  - `load`(`load_val`=7) on a tick edge with `out`=1 → `out`=7, no `tc`.
  - `rst` with `load` → `out`=0, IDLE.
  - One-shot load of 0 → HALT, `busy`=0, no `tc`.
- **Macro undefined**: `load_val`=3, `mode`=1, `en`=1 → `out` is 3,2,1,0 on consecutive cycles, with `tc` on the cycle `out`=0.

Source files
------------

// File: rtl/syn_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : syn_down_counter
//  Description : Synchronous loadable down counter with a clock-enable
//                prescaler, a one-cycle terminal-count pulse and selectable
//                wrap / one-shot behaviour. The prescaler only produces an
//                enable tick; everything runs on clk.
//
//  Parameters  : WIDTH    - counter width in bits (max value 2^WIDTH-1)
//                DIV_BITS - prescaler width; one tick per 2^DIV_BITS enabled
//                           RUN cycles (0 = tick on every enabled RUN cycle)
//
//  Ports       : clk      in  1      rising-edge clock
//                rst      in  1      synchronous active-high reset
//                en       in  1      count enable (freezes prescaler/counter)
//                load     in  1      load strobe
//                load_val in  WIDTH  value captured on load
//                mode     in  1      captured on load: 0 = wrap, 1 = one-shot
//                out      out WIDTH  current count (registered)
//                tc       out 1      terminal-count pulse (registered)
//                busy     out 1      high while running (registered)
//
//  Build macro : SYN_DOWN_COUNTER_PRESCALE_EN
//                defined   - prescaler registers are built, DIV_BITS applies
//                undefined - no prescaler, tick on every enabled RUN cycle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module syn_down_counter #(
    parameter int WIDTH    = 4,
    parameter int DIV_BITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_MAX  = '1;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             r_busy;
    logic             r_mode;

    logic             w_presc_full;
    logic             w_tick;

    // ------------------------------------------------------------------------
    // Prescaler: produces the "last cycle of the period" qualifier only.
    // ------------------------------------------------------------------------
`ifdef SYN_DOWN_COUNTER_PRESCALE_EN
    generate
        if (DIV_BITS > 0) begin : g_prescale
            logic [DIV_BITS-1:0] r_presc;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_presc <= '0;
                end else if (load) begin
                    // A fresh load restarts the period from the load edge.
                    r_presc <= '0;
                end else if (r_state == c_RUN && en) begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            assign w_presc_full = &r_presc;
        end else begin : g_prescale_bypass
            assign w_presc_full = 1'b1;
        end
    endgenerate
`else
    // DIV_BITS has no effect in this build; both branches tick every cycle.
    generate
        if (DIV_BITS > 0) begin : g_prescale_absent
            assign w_presc_full = 1'b1;
        end else begin : g_prescale_absent_zero
            assign w_presc_full = 1'b1;
        end
    endgenerate
`endif

    assign w_tick = (r_state == c_RUN) && en && w_presc_full;

    // ------------------------------------------------------------------------
    // Counter, mode latch and state. Priority: rst > load > tick.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_out   <= c_ZERO;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_mode  <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (load) begin
                r_out  <= load_val;
                r_mode <= mode;
                // A one-shot load of zero has nothing to count: finish silently.
                if (mode && load_val == c_ZERO) begin
                    r_state <= c_HALT;
                    r_busy  <= 1'b0;
                end else begin
                    r_state <= c_RUN;
                    r_busy  <= 1'b1;
                end
            end else if (w_tick) begin
                if (r_out == c_ONE) begin
                    r_out <= c_ZERO;
                    r_tc  <= 1'b1;
                    if (r_mode) begin
                        r_state <= c_HALT;
                        r_busy  <= 1'b0;
                    end
                end else if (r_out == c_ZERO) begin
                    // Only reachable in wrap mode; one-shot never runs at zero.
                    if (!r_mode) begin
                        r_out <= c_MAX;
                    end
                end else begin
                    r_out <= r_out - c_ONE;
                end
            end
        end
    end

    assign out  = r_out;
    assign tc   = r_tc;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_syn_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_syn_down_counter
//  Description : Self-checking bench for syn_down_counter (WIDTH=4,
//                DIV_BITS=2) against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_syn_down_counter;

    localparam int WIDTH    = 4;
    localparam int DIV_BITS = 2;
`ifdef SYN_DOWN_COUNTER_PRESCALE_EN
    localparam int PERIOD   = 1 << DIV_BITS;
`else
    localparam int PERIOD   = 1;
`endif
    localparam int MAXV     = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state as "what the counter is doing", time as a count
    // of enabled running cycles since the last load.
    int m_out     = 0;
    int m_mode    = 0;
    int m_running = 0;
    int m_encnt   = 0;
    int m_tc      = 0;

    syn_down_counter #(.WIDTH(WIDTH), .DIV_BITS(DIV_BITS)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .out(out), .tc(tc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        m_tc = 0;
        if (rst) begin
            m_out = 0; m_mode = 0; m_running = 0; m_encnt = 0;
        end else if (load) begin
            m_out     = int'(load_val);
            m_mode    = int'(mode);
            m_encnt   = 0;
            m_running = (mode && load_val == 0) ? 0 : 1;
        end else if (m_running == 1 && en) begin
            m_encnt++;
            if (m_encnt % PERIOD == 0) begin
                if (m_out == 1) begin
                    m_out = 0;
                    m_tc  = 1;
                    if (m_mode == 1) m_running = 0;
                end else if (m_out == 0) begin
                    m_out = MAXV;
                end else begin
                    m_out = m_out - 1;
                end
            end
        end
    endtask

    // Advance one clock: DUT and model see the same inputs; sample after #1.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; en = 1'b0;
        step(); step();
        rst = 1'b0; en = 1'b1;
        n_tests++;
        if ({out, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got out=%0d tc=%0b busy=%0b, want 0 0 0", out, tc, busy);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if ({out, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL idle_hold cyc%0d: got out=%0d tc=%0b busy=%0b, want 0 0 0", i, out, tc, busy);
            end
        end
    endtask

    task automatic test_oneshot();
        int tcs = 0;
        load = 1'b1; load_val = 4'd5; mode = 1'b1; en = 1'b1;
        step();
        load = 1'b0;
        n_tests++;
        if (out !== 4'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_load: got out=%0d busy=%0b, want 5 1", out, busy);
        end
        for (int i = 0; i < 5 * PERIOD + 20; i++) begin
            step();
            if (tc === 1'b1) tcs++;
            n_tests++;
            if ({out, tc, busy} !== {m_out[3:0], m_tc[0], m_running[0]}) begin
                n_fail++;
                $display("FAIL oneshot_cyc%0d: got out=%0d tc=%0b busy=%0b, want %0d %0d %0d",
                         i, out, tc, busy, m_out, m_tc, m_running);
            end
            if (i == 5 * PERIOD - 1) begin
                n_tests++;
                if (out !== 4'd0 || tc !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL oneshot_terminal: got out=%0d tc=%0b busy=%0b, want 0 1 0", out, tc, busy);
                end
            end
        end
        n_tests++;
        if (tcs != 1 || out !== 4'd0) begin
            n_fail++;
            $display("FAIL oneshot_tc_count: got tcs=%0d out=%0d, want 1 0", tcs, out);
        end
    endtask

    task automatic test_wrap();
        int seen[$];
        int exp_seq[6] = '{2, 1, 0, 15, 14, 13};
        int tcs = 0;
        load = 1'b1; load_val = 4'd2; mode = 1'b0; en = 1'b1;
        step();
        load = 1'b0;
        seen.push_back(int'(out));
        for (int i = 0; i < 5 * PERIOD; i++) begin
            step();
            if (tc === 1'b1) tcs++;
            if (int'(out) != seen[$]) seen.push_back(int'(out));
            n_tests++;
            if ({out, tc, busy} !== {m_out[3:0], m_tc[0], m_running[0]}) begin
                n_fail++;
                $display("FAIL wrap_cyc%0d: got out=%0d tc=%0b busy=%0b, want %0d %0d %0d",
                         i, out, tc, busy, m_out, m_tc, m_running);
            end
        end
        n_tests++;
        if (seen.size() != 6 || tcs != 1) begin
            n_fail++;
            $display("FAIL wrap_shape: got %0d values, %0d tc pulses, want 6 values, 1 pulse", seen.size(), tcs);
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (seen[k] != exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL wrap_seq[%0d]: got %0d, want %0d", k, seen[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_enable_gap();
        logic [WIDTH-1:0] held;
        int gap = 0;
        int found = 0;
        load = 1'b1; load_val = 4'd9; mode = 1'b1; en = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            step();
            if (out !== 4'd9) found = 1;
        end
        n_tests++;
        if (found == 0 || out !== 4'd8) begin
            n_fail++;
            $display("FAIL gap_first_dec: got out=%0d, want 8", out);
        end
        step(); step();
        en = 1'b0;
        held = out;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (out !== held || tc !== 1'b0 || out !== m_out[3:0]) begin
                n_fail++;
                $display("FAIL gap_frozen cyc%0d: got out=%0d tc=%0b, want %0d 0", i, out, tc, held);
            end
        end
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            step();
            gap++;
            if (out !== held) found = 1;
        end
        n_tests++;
        if (found == 0 || gap != PERIOD - (2 % PERIOD) || out !== m_out[3:0]) begin
            n_fail++;
            $display("FAIL gap_resume: got gap=%0d out=%0d, want gap=%0d out=%0d",
                     gap, out, PERIOD - (2 % PERIOD), m_out);
        end
    endtask

    task automatic test_collisions();
        // Load on the same edge as the tick that would take 1 -> 0.
        load = 1'b1; load_val = 4'd1; mode = 1'b0; en = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < PERIOD - 1; i++) step();
        load = 1'b1; load_val = 4'd7;
        step();
        load = 1'b0;
        n_tests++;
        if (out !== 4'd7 || tc !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_load_tick: got out=%0d tc=%0b busy=%0b, want 7 0 1", out, tc, busy);
        end
        // Reset beats a simultaneous load.
        rst = 1'b1; load = 1'b1; load_val = 4'd5;
        step();
        rst = 1'b0; load = 1'b0;
        n_tests++;
        if (out !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_rst_load: got out=%0d busy=%0b tc=%0b, want 0 0 0", out, busy, tc);
        end
        for (int i = 0; i < 2 * PERIOD + 2; i++) step();
        n_tests++;
        if (out !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_rst_idle: got out=%0d busy=%0b, want 0 0", out, busy);
        end
        // One-shot load of zero.
        load = 1'b1; load_val = 4'd0; mode = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 2; i++) begin
            step();
            n_tests++;
            if (out !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL coll_oneshot_zero cyc%0d: got out=%0d busy=%0b tc=%0b, want 0 0 0", i, out, busy, tc);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 11) == 0);
            load_val = WIDTH'($urandom_range(0, MAXV));
            mode     = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 3) != 0);
            step();
            n_tests++;
            if ({out, tc, busy} !== {m_out[3:0], m_tc[0], m_running[0]}) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got out=%0d tc=%0b busy=%0b, want %0d %0d %0d",
                         i, out, tc, busy, m_out, m_tc, m_running);
            end
        end
        rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_wrap();
        test_enable_gap();
        test_collisions();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
